sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 init_end  input  1  level; power-up init sequence complete.
REQ-004 init_cmd / init_addr  input  4 / 13  init-stage command {cs_n,ras_n,cas_n,we_n} and address.
REQ-005 aref_req  input  1  refresh request, level.
REQ-006 flag_aref_end  input  1  one-cycle pulse; refresh finished.
REQ-007 aref_cmd / aref_addr  input  4 / 13  refresh-stage command and address.
REQ-008 wr_req  input  1  write request, level.
REQ-009 flag_wr_end  input  1  one-cycle pulse; write stage released the bus.
REQ-010 wr_cmd / wr_addr / wr_data  input  4 / 13 / 16  write-stage command, address, data.
REQ-011 rd_req  input  1  read request, level.
REQ-012 flag_rd_end  input  1  one-cycle pulse; read stage released the bus.
REQ-013 rd_cmd / rd_addr  input  4 / 13  read-stage command and address.
REQ-014 aref_en / wr_en / rd_en  output  1 each  grant to the refresh, write and read stages.
REQ-015 sdram_cmd  output  4  muxed command {cs_n,ras_n,cas_n,we_n}.
REQ-016 sdram_addr  output  13  muxed address.
REQ-017 sdram_ba  output  2  bank address; constant 2'b00.
REQ-018 sdram_dq_out  output  16  write data to the pad tristate.
REQ-019 sdram_dq_oe  output  1  pad output enable.

Function
REQ-020 The FSM SHALL be one-hot with states ARB_INIT, ARB_IDLE, ARB_AREF, ARB_WRITE and ARB_READ.
REQ-021 From ARB_INIT, the FSM SHALL move to ARB_IDLE on the first cycle init_end=1.
REQ-022 In ARB_IDLE, the next state SHALL be chosen in fixed priority: aref_req -> ARB_AREF; else wr_req -> ARB_WRITE; else rd_req -> ARB_READ (subject to REQ-034); else stay in ARB_IDLE.
REQ-023 ARB_AREF, ARB_WRITE and ARB_READ SHALL return to ARB_IDLE on flag_aref_end, flag_wr_end and flag_rd_end respectively. End pulses that do not belong to the current state SHALL be ignored.
REQ-024 Each grant SHALL be combinational:
  - aref_en = (state==ARB_AREF) && !flag_aref_end
  - wr_en = (state==ARB_WRITE) && !flag_wr_end
  - rd_en = (state==ARB_READ) && !flag_rd_end
  - At most one grant SHALL be high in any cycle.
REQ-025 Grant latency: a request sampled in ARB_IDLE at edge N SHALL raise its grant in cycle N+1. Minimum idle-to-grant is one cycle.
REQ-026 A grant SHALL never be high in the cycle its end pulse arrives. This stops a stage that re-enters its request state on the same cycle from being re-granted.
REQ-027 sdram_cmd / sdram_addr SHALL be a combinational mux on the current state:
  - ARB_INIT -> init_cmd / init_addr
  - ARB_AREF -> aref_cmd / aref_addr
  - ARB_WRITE -> wr_cmd / wr_addr
  - ARB_READ -> rd_cmd / rd_addr
  - ARB_IDLE -> 4'b0111 (NOP) / 13'h0400
REQ-028 sdram_dq_oe SHALL be 1 only in ARB_WRITE.
REQ-029 sdram_dq_out SHALL equal wr_data in ARB_WRITE and 16'h0000 otherwise.
REQ-030 A request that arrives while another stage holds the bus SHALL be held pending (the request is level) and SHALL be arbitrated on return to ARB_IDLE.
REQ-031 When aref_req rises during ARB_WRITE or ARB_READ, the arbiter SHALL NOT preempt. It SHALL wait for the owning stage's end pulse; the stages break themselves.

Reset
REQ-032 While rst_n=0, the following SHALL hold:
  - state = ARB_INIT
  - all grants 0
  - sdram_cmd = init_cmd, sdram_addr = init_addr
  - sdram_dq_oe = 0, sdram_dq_out = 0
  - round-robin pointer (if compiled) = write-first
REQ-033 Reset asserted mid-operation SHALL abort the current grant immediately (asynchronous), and the FSM SHALL re-enter ARB_INIT.

Configuration
REQ-034 Macro ARBIT_RR_EN:
  - Defined: a 1-bit last_grant register SHALL be updated on each entry to ARB_WRITE (set to write) or ARB_READ (set to read). When wr_req and rd_req are both 1 in ARB_IDLE with no aref_req, the stage not in last_grant SHALL win.
  - Not defined: write SHALL always beat read, and no last_grant register SHALL exist.
  - In both builds, refresh SHALL keep absolute priority.

Verification
REQ-035 Init: hold init_end=0 for 100 cycles, then set it to 1.
  - While 0: sdram_cmd == init_cmd.
  - After init_end=1: state ARB_IDLE, sdram_cmd == 4'b0111, sdram_addr == 13'h0400.
REQ-036 Write: pulse wr_req=1 in ARB_IDLE, with wr_data=16'hA5A5.
  - wr_en=1 next cycle; dq_oe=1; dq_out == 16'hA5A5; sdram_cmd tracks wr_cmd.
  - On flag_wr_end: wr_en=0 in that same cycle; ARB_IDLE next cycle.
REQ-037 Collision: aref_req and wr_req both 1 in ARB_IDLE.
  - aref_en granted first.
  - After flag_aref_end, wr_en=1 two cycles later.
REQ-038 No preemption: raise aref_req during ARB_WRITE.
  - wr_en stays 1 until flag_wr_end.
  - The next cycle enters ARB_AREF, not ARB_WRITE, even though wr_req is still 1.
REQ-039 ARBIT_RR_EN build: hold wr_req and rd_req at 1 continuously, pulsing each end flag after 8 cycles.
  - Grants alternate W, R, W, R.
  - Without the macro: W, W, W.
REQ-040 Reset: assert rst_n=0 during ARB_READ.
  - rd_en drops asynchronously.
  - After release: state ARB_INIT, sdram_cmd == init_cmd.

Source files
------------

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: refresh > write > read, grants and bus mux are combinational.
// Optional ARBIT_RR_EN: write/read alternate when both request together.
module sdram_arbit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        flag_aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [12:0] ADDR_IDL = 13'h0400;

    typedef enum logic [4:0] {
        ARB_INIT  = 5'b00001,
        ARB_IDLE  = 5'b00010,
        ARB_AREF  = 5'b00100,
        ARB_WRITE = 5'b01000,
        ARB_READ  = 5'b10000
    } state_t;

    state_t state, state_n;
    logic   rd_first;

`ifdef ARBIT_RR_EN
    // last_rd=1 means read was granted last; reset value lets write go first
    logic last_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd <= 1'b1;
        end else if (state == ARB_IDLE && state_n == ARB_WRITE) begin
            last_rd <= 1'b0;
        end else if (state == ARB_IDLE && state_n == ARB_READ) begin
            last_rd <= 1'b1;
        end
    end

    assign rd_first = ~last_rd;
`else
    assign rd_first = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARB_INIT: begin
                if (init_end) state_n = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (aref_req) begin
                    state_n = ARB_AREF;
                end else if (wr_req && !(rd_req && rd_first)) begin
                    state_n = ARB_WRITE;
                end else if (rd_req) begin
                    state_n = ARB_READ;
                end
            end
            ARB_AREF: begin
                if (flag_aref_end) state_n = ARB_IDLE;
            end
            ARB_WRITE: begin
                if (flag_wr_end) state_n = ARB_IDLE;
            end
            ARB_READ: begin
                if (flag_rd_end) state_n = ARB_IDLE;
            end
            default: state_n = ARB_INIT;
        endcase
    end

    // End pulse masks its own grant so a stage cannot be re-granted that cycle
    always_comb begin
        aref_en      = (state == ARB_AREF) && !flag_aref_end;
        wr_en        = (state == ARB_WRITE) && !flag_wr_end;
        rd_en        = (state == ARB_READ) && !flag_rd_end;
        sdram_ba     = 2'b00;
        sdram_dq_oe  = (state == ARB_WRITE);
        sdram_dq_out = (state == ARB_WRITE) ? wr_data : 16'h0000;
        sdram_cmd    = init_cmd;
        sdram_addr   = init_addr;
        unique case (state)
            ARB_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ARB_IDLE: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = ADDR_IDL;
            end
            ARB_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ARB_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
            end
            ARB_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: directed table, corner sequences, random vs model.
// Expects write/read alternation when built with ARBIT_RR_EN.
module tb_sdram_arbit;

`ifdef ARBIT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        aref_req, flag_aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        wr_req, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    sdram_arbit dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .flag_aref_end(flag_aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_ba(sdram_ba), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model owner: 0 init, 1 idle, 2 refresh, 3 write, 4 read
    int ms;
    bit m_last_rd;

    typedef struct {
        logic ie, ar, wr, rd, fa, fw, fr;
        logic ea, ew, er, eoe;
        logic [3:0] ecmd;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int model_next();
        case (ms)
            0: return init_end ? 1 : 0;
            1: begin
                if (aref_req) return 2;
                if (wr_req && rd_req) return (RR && !m_last_rd) ? 4 : 3;
                if (wr_req) return 3;
                if (rd_req) return 4;
                return 1;
            end
            2: return flag_aref_end ? 1 : 2;
            3: return flag_wr_end ? 1 : 3;
            4: return flag_rd_end ? 1 : 4;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        int nx;
        nx = model_next();
        @(posedge clk);
        if (rst_n) begin
            if (ms == 1 && nx == 3) m_last_rd = 1'b0;
            if (ms == 1 && nx == 4) m_last_rd = 1'b1;
            ms = nx;
        end
        #1;
    endtask

    task automatic check_model();
        logic [3:0]  c;
        logic [12:0] a;
        case (ms)
            0: begin c = init_cmd; a = init_addr; end
            1: begin c = 4'b0111; a = 13'h0400; end
            2: begin c = aref_cmd; a = aref_addr; end
            3: begin c = wr_cmd; a = wr_addr; end
            default: begin c = rd_cmd; a = rd_addr; end
        endcase
        chk("m_aref_en", 32'(aref_en), 32'(ms == 2 && !flag_aref_end));
        chk("m_wr_en", 32'(wr_en), 32'(ms == 3 && !flag_wr_end));
        chk("m_rd_en", 32'(rd_en), 32'(ms == 4 && !flag_rd_end));
        chk("m_one_grant", 32'(aref_en + wr_en + rd_en <= 2'd1), 32'd1);
        chk("m_cmd", 32'(sdram_cmd), 32'(c));
        chk("m_addr", 32'(sdram_addr), 32'(a));
        chk("m_ba", 32'(sdram_ba), 32'd0);
        chk("m_oe", 32'(sdram_dq_oe), 32'(ms == 3));
        chk("m_dq", 32'(sdram_dq_out), (ms == 3) ? 32'(wr_data) : 32'd0);
    endtask

    task automatic clr_in();
        init_end = 0; aref_req = 0; wr_req = 0; rd_req = 0;
        flag_aref_end = 0; flag_wr_end = 0; flag_rd_end = 0;
    endtask

    task automatic fixed_cmds();
        init_cmd = 4'h1; init_addr = 13'h0011;
        aref_cmd = 4'h2; aref_addr = 13'h0022;
        wr_cmd   = 4'h3; wr_addr   = 13'h0033;
        rd_cmd   = 4'h4; rd_addr   = 13'h0044;
        wr_data  = 16'hA5A5;
    endtask

    function automatic logic [12:0] addr_of(input logic [3:0] c);
        case (c)
            4'h1: return 13'h0011;
            4'h2: return 13'h0022;
            4'h3: return 13'h0033;
            4'h4: return 13'h0044;
            default: return 13'h0400;
        endcase
    endfunction

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        ms = 0;
        m_last_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        #1 rst_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] in, input logic [3:0] eg,
                                input logic [3:0] ec);
        vec_t v;
        {v.ie, v.ar, v.wr, v.rd, v.fa, v.fw, v.fr} = in;
        {v.ea, v.ew, v.er, v.eoe} = eg;
        v.ecmd = ec;
        return v;
    endfunction

    initial begin
        // inputs: ie ar wr rd fa fw fr ; expect: ea ew er oe
        tbl[0]  = mk(7'b1000000, 4'b0000, 4'h7);
        tbl[1]  = mk(7'b1010000, 4'b0000, 4'h7);
        tbl[2]  = mk(7'b1000000, 4'b0101, 4'h3);
        tbl[3]  = mk(7'b1000010, 4'b0001, 4'h3);
        tbl[4]  = mk(7'b1110000, 4'b0000, 4'h7);
        tbl[5]  = mk(7'b1110000, 4'b1000, 4'h2);
        tbl[6]  = mk(7'b1010100, 4'b0000, 4'h2);
        tbl[7]  = mk(7'b1010000, 4'b0000, 4'h7);
        tbl[8]  = mk(7'b1110000, 4'b0101, 4'h3);
        tbl[9]  = mk(7'b1110010, 4'b0001, 4'h3);
        tbl[10] = mk(7'b1110000, 4'b0000, 4'h7);
        tbl[11] = mk(7'b1110000, 4'b1000, 4'h2);
        tbl[12] = mk(7'b1001100, 4'b0000, 4'h2);
        tbl[13] = mk(7'b1001000, 4'b0000, 4'h7);
        tbl[14] = mk(7'b1001010, 4'b0010, 4'h4);
        tbl[15] = mk(7'b1000001, 4'b0000, 4'h4);
        tbl[16] = mk(7'b1000000, 4'b0000, 4'h7);

        fixed_cmds();
        do_reset();

        // Init phase: cmd follows a changing init_cmd for 100 cycles
        for (int i = 0; i < 100; i++) begin
            init_cmd = 4'($urandom);
            init_addr = 13'($urandom);
            #1;
            chk("init_cmd", 32'(sdram_cmd), 32'(init_cmd));
            chk("init_addr", 32'(sdram_addr), 32'(init_addr));
            chk("init_grant", 32'({aref_en, wr_en, rd_en}), 32'd0);
            tick();
        end
        fixed_cmds();
        init_end = 1'b1;
        tick();
        chk("idle_cmd", 32'(sdram_cmd), 32'h7);
        chk("idle_addr", 32'(sdram_addr), 32'h0400);

        // Directed table starting from idle
        for (int i = 0; i < 17; i++) begin
            {init_end, aref_req, wr_req, rd_req} =
                {tbl[i].ie, tbl[i].ar, tbl[i].wr, tbl[i].rd};
            {flag_aref_end, flag_wr_end, flag_rd_end} =
                {tbl[i].fa, tbl[i].fw, tbl[i].fr};
            #1;
            chk($sformatf("t%0d_grants", i),
                32'({aref_en, wr_en, rd_en, sdram_dq_oe}),
                32'({tbl[i].ea, tbl[i].ew, tbl[i].er, tbl[i].eoe}));
            chk($sformatf("t%0d_cmd", i), 32'(sdram_cmd), 32'(tbl[i].ecmd));
            chk($sformatf("t%0d_addr", i), 32'(sdram_addr),
                32'(addr_of(tbl[i].ecmd)));
            chk($sformatf("t%0d_dq", i), 32'(sdram_dq_out),
                tbl[i].eoe ? 32'hA5A5 : 32'd0);
            tick();
        end
        clr_in();

        // Both write and read held: order of grants
        do_reset();
        init_end = 1'b1;
        tick();
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w;
            bit got_w;
            w = 0;
            while (!wr_en && !rd_en && w < 10) begin
                tick();
                w++;
            end
            chk($sformatf("rr%0d_timeout", k), 32'(w < 10), 32'd1);
            got_w = wr_en;
            chk($sformatf("rr%0d_is_write", k), 32'(got_w),
                32'(RR ? (k % 2 == 0) : 1'b1));
            repeat (7) tick();
            if (got_w) flag_wr_end = 1'b1;
            else flag_rd_end = 1'b1;
            #1;
            chk($sformatf("rr%0d_end_mask", k), 32'({wr_en, rd_en}), 32'd0);
            tick();
            flag_wr_end = 1'b0;
            flag_rd_end = 1'b0;
        end
        clr_in();

        // Asynchronous reset during a read
        do_reset();
        init_end = 1'b1;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk("rst_rd_before", 32'(rd_en), 32'd1);
        #2 rst_n = 1'b0;
        ms = 0;
        m_last_rd = 1'b1;
        #1;
        chk("rst_rd_async", 32'(rd_en), 32'd0);
        chk("rst_cmd_async", 32'(sdram_cmd), 32'h1);
        chk("rst_oe", 32'(sdram_dq_oe), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_after_cmd", 32'(sdram_cmd), 32'h1);
        chk("rst_after_addr", 32'(sdram_addr), 32'h0011);
        chk("rst_after_grant", 32'({aref_en, wr_en, rd_en}), 32'd0);
        tick();
        chk("rst_then_idle", 32'(sdram_cmd), 32'h7);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            init_end      = ($urandom % 8 == 0);
            aref_req      = ($urandom % 6 == 0);
            wr_req        = 1'($urandom);
            rd_req        = 1'($urandom);
            flag_aref_end = ($urandom % 4 == 0);
            flag_wr_end   = ($urandom % 4 == 0);
            flag_rd_end   = ($urandom % 4 == 0);
            init_cmd  = 4'($urandom);  init_addr = 13'($urandom);
            aref_cmd  = 4'($urandom);  aref_addr = 13'($urandom);
            wr_cmd    = 4'($urandom);  wr_addr   = 13'($urandom);
            rd_cmd    = 4'($urandom);  rd_addr   = 13'($urandom);
            wr_data   = 16'($urandom);
            #1;
            check_model();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
